// File: rtl/apu_frame_counter_if.sv
// APU frame counter register/pulse bus.
// master: CPU/APU side driving $4017 writes and $4015 reads.
// slave: the frame counter itself.
interface apu_frame_counter_if;
    logic       reg_write;     // one-cycle $4017 write strobe
    logic [7:0] reg_4017;      // bit7 = 5-step mode, bit6 = irq inhibit
    logic       irq_clear;     // one-cycle $4015 read strobe
    logic       enable_240hz;  // quarter-frame pulse
    logic       enable_120hz;  // half-frame pulse
    logic       frame_irq;     // frame interrupt flag
    logic [2:0] step;          // current sequencer step

    modport master (
        output reg_write, reg_4017, irq_clear,
        input  enable_240hz, enable_120hz, frame_irq, step
    );

    modport slave (
        input  reg_write, reg_4017, irq_clear,
        output enable_240hz, enable_120hz, frame_irq, step
    );
endinterface

// File: rtl/apu_frame_counter.sv
// APU frame counter: DIVIDER-cycle prescaler drives a 4- or 5-step
// sequencer that emits quarter/half-frame pulses and the frame IRQ.
// Optional macro FRAME_IRQ_EN: when defined, the frame IRQ flag, its
// inhibit bit and clear logic are built; otherwise frame_irq is tied 0.
module apu_frame_counter #(
    parameter int DIVIDER = 7457
) (
    input  logic                clk,
    input  logic                rst,
    apu_frame_counter_if.slave  bus
);

    localparam logic [15:0] PRE_LAST = 16'(DIVIDER - 1);

    logic [15:0] presc_q, presc_d;
    logic [2:0]  step_q, step_d;
    logic        mode_q, mode_d;
    logic        q_q, q_d;
    logic        h_q, h_d;
    logic        tick;
    logic [2:0]  last_step;

`ifdef FRAME_IRQ_EN
    logic        inh_q, inh_d;
    logic        irq_q, irq_d;
    logic        irq_set;
    logic        unused_data;
    assign unused_data = ^bus.reg_4017[5:0];
`else
    logic        unused_data;
    assign unused_data = ^{bus.irq_clear, bus.reg_4017[6:0]};
`endif

    assign tick      = (presc_q == PRE_LAST);
    assign last_step = mode_q ? 3'd4 : 3'd3;

    // State register: prescaler, sequencer step, mode and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            step_q  <= '0;
            mode_q  <= 1'b0;
            q_q     <= 1'b0;
            h_q     <= 1'b0;
`ifdef FRAME_IRQ_EN
            inh_q   <= 1'b0;
            irq_q   <= 1'b0;
`endif
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            q_q     <= q_d;
            h_q     <= h_d;
`ifdef FRAME_IRQ_EN
            inh_q   <= inh_d;
            irq_q   <= irq_d;
`endif
        end
    end

    // Next-state: prescaler wrap, step advance, and $4017 write restart
    always_comb begin
        presc_d = tick ? '0 : presc_q + 16'd1;
        step_d  = step_q;
        mode_d  = mode_q;
        if (tick)
            step_d = (step_q >= last_step) ? 3'd0 : step_q + 3'd1;
        // A write restarts the sequence and swallows a coincident tick, which
        // also keeps step in range when dropping from 5-step to 4-step.
        if (bus.reg_write) begin
            mode_d  = bus.reg_4017[7];
            presc_d = '0;
            step_d  = '0;
        end
    end

    // Output decode: pulses and IRQ set for the step being ticked out of
    always_comb begin
        q_d = 1'b0;
        h_d = 1'b0;
`ifdef FRAME_IRQ_EN
        irq_set = 1'b0;
`endif
        if (bus.reg_write) begin
            q_d = bus.reg_4017[7];
            h_d = bus.reg_4017[7];
        end else if (tick) begin
            case (step_q)
                3'd0: q_d = 1'b1;
                3'd1: begin q_d = 1'b1; h_d = 1'b1; end
                3'd2: q_d = 1'b1;
                3'd3: begin
                    q_d = !mode_q;
                    h_d = !mode_q;
`ifdef FRAME_IRQ_EN
                    irq_set = !mode_q;
`endif
                end
                3'd4: begin q_d = mode_q; h_d = mode_q; end
                default: ;
            endcase
        end
    end

`ifdef FRAME_IRQ_EN
    // IRQ flag: write-inhibit and status read clear it, a new set wins
    always_comb begin
        inh_d = bus.reg_write ? bus.reg_4017[6] : inh_q;
        irq_d = irq_q;
        if (bus.irq_clear)
            irq_d = 1'b0;
        if (bus.reg_write && bus.reg_4017[6])
            irq_d = 1'b0;
        if (irq_set && !inh_q)
            irq_d = 1'b1;
    end

    assign bus.frame_irq = irq_q;
`else
    assign bus.frame_irq = 1'b0;
`endif

    assign bus.enable_240hz = q_q;
    assign bus.enable_120hz = h_q;
    assign bus.step         = step_q;

endmodule

// File: tb/tb_apu_frame_counter.sv
// Directed bench for apu_frame_counter with DIVIDER=10.
module tb_apu_frame_counter;

`ifdef FRAME_IRQ_EN
    localparam bit IRQ_EN = 1'b1;
`else
    localparam bit IRQ_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   errors  = 0;

    apu_frame_counter_if bus();

    apu_frame_counter #(.DIVIDER(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, obs, exp);
        end
    endtask

    // Advance one clock (inputs already driven), sample 1ns after the edge,
    // drop the strobes, then check all four outputs.
    task automatic cyc(input string tag, input bit q, input bit h, input bit irq, input int st);
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        bus.irq_clear = 1'b0;
        check({tag, ".q"},    8'(bus.enable_240hz), 8'(q));
        check({tag, ".h"},    8'(bus.enable_120hz), 8'(h));
        check({tag, ".irq"},  8'(bus.frame_irq),    8'(irq & IRQ_EN));
        check({tag, ".step"}, 8'(bus.step),         8'(st));
    endtask

    initial begin
        bus.reg_write = 1'b0;
        bus.reg_4017  = 8'h00;
        bus.irq_clear = 1'b0;

        // Reset state
        rst = 1'b1;
        cyc("rst0", 0, 0, 0, 0);
        cyc("rst1", 0, 0, 0, 0);
        rst = 1'b0;

        // 4-step from reset: Q at 10..40, H at 20/40, IRQ at 40
        for (int c = 1; c <= 40; c++)
            cyc("m4", (c % 10) == 0, (c % 20) == 0, c >= 40, (c / 10) % 4);

        // Status read clears the flag next cycle
        bus.irq_clear = 1'b1;
        cyc("clr", 0, 0, 0, 0);

        // Second frame: status read coincident with step-3 tick, set wins
        for (int c = 42; c <= 80; c++) begin
            bus.irq_clear = (c == 80);
            cyc("setwin", (c % 10) == 0, (c % 20) == 0, c == 80, (c / 10) % 4);
        end

        // Inhibit write clears the pending flag; no IRQ for 100 cycles
        bus.reg_write = 1'b1;
        bus.reg_4017  = 8'h40;
        cyc("inh_wr", 0, 0, 0, 0);
        for (int k = 1; k <= 100; k++)
            cyc("inh", (k % 10) == 0, (k % 20) == 0, 0, (k / 10) % 4);

        // 5-step write: immediate Q+H, then Q@10,20,30, none@40, Q+H@50
        bus.reg_write = 1'b1;
        bus.reg_4017  = 8'h80;
        cyc("m5_wr", 1, 1, 0, 0);
        for (int k = 1; k <= 50; k++)
            cyc("m5", k == 10 || k == 20 || k == 30 || k == 50,
                k == 20 || k == 50, 0, (k / 10) % 5);

        // Write coincident with tick: tick discarded, restart from step 0
        for (int k = 51; k <= 59; k++)
            cyc("pre_coin", 0, 0, 0, 0);
        bus.reg_write = 1'b1;
        bus.reg_4017  = 8'h00;
        cyc("coin_wr", 0, 0, 0, 0);
        for (int j = 1; j <= 25; j++)
            cyc("coin", j == 10 || j == 20, j == 20, 0, j / 10);

        // Reset in the middle of step 2, then a full period before first tick
        rst = 1'b1;
        cyc("mid_rst0", 0, 0, 0, 0);
        cyc("mid_rst1", 0, 0, 0, 0);
        rst = 1'b0;
        for (int c = 1; c <= 20; c++)
            cyc("restart", (c % 10) == 0, c == 20, 0, c / 10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/apu_frame_counter.md
APU_FRAME_COUNTER -- requirements
Module: apu_frame_counter

Interface
REQ-001 SHALL have parameter DIVIDER, default 7457, giving clk cycles per 240 Hz step tick (1.789773 MHz / 240); legal range 2..65535.
REQ-002 SHALL have port clk  input  1  system clock, single clock domain.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port reg_write  input  1  one-cycle strobe indicating a $4017 write.
REQ-005 SHALL have port reg_4017  input  8  write data, sampled only when reg_write=1; bit7 = mode (0: 4-step, 1: 5-step), bit6 = irq_inhibit.
REQ-006 SHALL have port irq_clear  input  1  one-cycle strobe indicating a $4015 status read.
REQ-007 SHALL have port enable_240hz  output  1  registered one-cycle quarter-frame pulse for envelope units.
REQ-008 SHALL have port enable_120hz  output  1  registered one-cycle half-frame pulse for length and sweep units.
REQ-009 SHALL have port frame_irq  output  1  registered frame interrupt flag.
REQ-010 SHALL have port step  output  3  current sequencer step index.

Function
REQ-011 SHALL contain a prescaler counting 0..DIVIDER-1; "tick" is defined as the cycle where the prescaler equals DIVIDER-1; prescaler then wraps to 0.
REQ-012 SHALL contain a step counter; last step = 3 in 4-step mode, 4 in 5-step mode; on tick step advances, wrapping from last step to 0.
REQ-013 SHALL, on tick with step=s in 4-step mode, drive the cycle after tick: s0 Q; s1 Q+H; s2 Q; s3 Q+H+irq-set (Q = enable_240hz, H = enable_120hz).
REQ-014 SHALL, on tick with step=s in 5-step mode, drive: s0 Q; s1 Q+H; s2 Q; s3 nothing; s4 Q+H; never irq-set.
REQ-015 SHALL keep enable_240hz and enable_120hz low on every cycle not listed in REQ-013/014/018; each pulse exactly one clk wide.
REQ-016 SHALL set frame_irq on irq-set only when irq_inhibit=0; frame_irq then holds until cleared.
REQ-017 SHALL clear frame_irq the cycle after irq_clear=1; irq-set and irq_clear in the same cycle SHALL leave frame_irq=1 (set wins).
REQ-018 SHALL, on reg_write: latch mode and irq_inhibit, force prescaler=0 and step=0; if bit7=1, emit one Q and one H pulse on the following cycle; if bit6=1, clear frame_irq on the following cycle.
REQ-019 SHALL give reg_write priority over a coincident tick: the tick's pulses, irq-set and step advance are discarded.
REQ-020 SHALL handle a mode change 5-step to 4-step while step=4 safely: the reset in REQ-018 makes step 0, so step never exceeds the last step of the active mode.
REQ-021 SHALL register all outputs; latency tick-to-pulse and write-to-pulse is exactly 1 cycle.

Reset
REQ-022 SHALL, while rst=1, force prescaler=0, step=0, mode=0, irq_inhibit=0, enable_240hz=0, enable_120hz=0, frame_irq=0.
REQ-023 SHALL give rst priority over reg_write, irq_clear and tick; reset mid-sequence SHALL restart at step 0 with a full DIVIDER period before the first tick.

Configuration
REQ-024 SHALL honour macro FRAME_IRQ_EN: when defined, frame_irq behaves per REQ-016/017/018; when undefined, frame_irq is constant 0, irq_inhibit storage and IRQ logic are removed, and sequencing/pulses are unchanged.

Verification (DIVIDER=10)
REQ-025 SHALL verify: release rst, 4-step -> Q pulses at cycles 10,20,30,40 after release; H at 20,40; frame_irq rises at 40; step sequence 1,2,3,0.
REQ-026 SHALL verify: reg_write with data 0x80 -> Q+H pulse the next cycle, then Q at +10,+20,+30, none at +40, Q+H at +50; frame_irq stays 0.
REQ-027 SHALL verify: frame_irq=1 with irq_clear pulse -> frame_irq=0 next cycle; irq_clear coincident with step-3 tick -> frame_irq stays 1.
REQ-028 SHALL verify: reg_write with data 0x40 while frame_irq=1 -> frame_irq=0 next cycle; no further IRQ over 100 cycles.
REQ-029 SHALL verify: reg_write coincident with tick -> no pulse from that tick, step=0, next Q exactly 10 cycles later; rst asserted mid-step 2 -> all outputs 0, restart from step 0.
REQ-030 SHALL verify: build without FRAME_IRQ_EN, repeat REQ-025 -> identical Q/H pulses, frame_irq constant 0.
